// File: rtl/rms_pkg.sv
// Shared types and helpers for the streaming RMS block.
package rms_pkg;

   typedef enum logic [1:0] {
      ACCUM,
      DIV,
      SQRT,
      DONE
   } rms_state_e;

   // Ceiling log2, usable in parameter/localparam expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rms_stream_if.sv
// Sample-in / result-out handshake bundle for rms_stream.
interface rms_stream_if #(
   parameter int SW = 4
);

   logic            in_valid;
   logic            in_ready;
   logic [SW-1:0]   in_sample;
   logic            out_valid;
   logic            out_ready;
   logic [SW-1:0]   out_rms;
   logic [2*SW-1:0] out_mean;

   modport master (
      output in_valid, in_sample, out_ready,
      input  in_ready, out_valid, out_rms, out_mean
   );

   modport slave (
      input  in_valid, in_sample, out_ready,
      output in_ready, out_valid, out_rms, out_mean
   );

endinterface

// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit integer square root, one root bit per cycle.
// start loads the radicand; SW cycles later done is high with the root.
module isqrt_seq
   import rms_pkg::*;
#(
   parameter int SW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2*SW-1:0] radicand,
   output logic [SW-1:0]   root,
   output logic            done
);

   localparam int CW  = clog2(SW + 1);
   localparam int RMW = SW + 2;

   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*SW-1:0] rad_q, rad_d;
   logic [RMW-1:0]  rem_q, rem_d;
   logic [SW-1:0]   root_q, root_d;
   logic [RMW-1:0]  trial;
   logic [RMW-1:0]  test;

   // One bit-pair step: bring down two radicand bits, try appending a 1 to the root.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rad_d  = rad_q;
      rem_d  = rem_q;
      root_d = root_q;
      trial  = '0;
      test   = '0;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(SW);
         rad_d  = radicand;
         rem_d  = '0;
         root_d = '0;
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            trial = (rem_q << 2) | RMW'(rad_q[2*SW-1 -: 2]);
            test  = {root_q, 2'b01};
            rad_d = rad_q << 2;
            cnt_d = cnt_q - CW'(1);
            if (trial >= test) begin
               rem_d  = trial - test;
               root_d = (root_q << 1) | SW'(1);
            end else begin
               rem_d  = trial;
               root_d = root_q << 1;
            end
         end
      end
   end

   // Iteration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
      end
   end

   assign root = root_q;
   assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/rms_stream.sv
// Streaming RMS: accumulates N squared samples, divides by N with a
// restoring divider, then takes an integer square root.
module rms_stream
   import rms_pkg::*;
#(
   parameter int SW = 4,
   parameter int N  = 5
) (
   input  logic         clk,
   input  logic         rst,
   rms_stream_if.slave  bus
);

   localparam int ACCW = 2*SW + clog2(N);
   localparam int CNW  = clog2(N);
   localparam int STW  = clog2(ACCW);
   localparam int RW   = clog2(N) + 1;

   rms_state_e      state_q, state_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [CNW-1:0]  cnt_q, cnt_d;
   logic [STW-1:0]  step_q, step_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic            out_valid_q, out_valid_d;
   logic [SW-1:0]   out_rms_q, out_rms_d;
   logic [2*SW-1:0] out_mean_q, out_mean_d;

   logic [ACCW-1:0] sample_ext;
   logic [ACCW-1:0] sample_sq;
   logic [RW-1:0]   shifted;
   logic            qbit;
   logic            sqrt_start;
   logic [2*SW-1:0] sqrt_radicand;
   logic [SW-1:0]   sqrt_root;
   logic            sqrt_done;

   // Next-state logic. During DIV the accumulator doubles as the dividend
   // shift register, with quotient bits shifted in at the bottom.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      step_d        = step_q;
      rem_d         = rem_q;
      out_valid_d   = out_valid_q;
      out_rms_d     = out_rms_q;
      out_mean_d    = out_mean_q;
      sample_ext    = ACCW'(bus.in_sample);
      sample_sq     = sample_ext * sample_ext;
      shifted       = '0;
      qbit          = 1'b0;
      sqrt_start    = 1'b0;
      case (state_q)
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d = acc_q + sample_sq;
               if (cnt_q == CNW'(N - 1)) begin
                  cnt_d   = '0;
                  step_d  = '0;
                  rem_d   = '0;
                  state_d = DIV;
               end else begin
                  cnt_d = cnt_q + CNW'(1);
               end
            end
         end
         DIV: begin
            shifted = (rem_q << 1) | RW'(acc_q[ACCW-1]);
            if (shifted >= RW'(N)) begin
               rem_d = shifted - RW'(N);
               qbit  = 1'b1;
            end else begin
               rem_d = shifted;
            end
            acc_d  = {acc_q[ACCW-2:0], qbit};
            step_d = step_q + STW'(1);
            if (step_q == STW'(ACCW - 1)) begin
               sqrt_start = 1'b1;
               state_d    = SQRT;
            end
         end
         SQRT: begin
            if (sqrt_done) begin
               out_valid_d = 1'b1;
               out_rms_d   = sqrt_root;
               out_mean_d  = acc_q[2*SW-1:0];
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
      sqrt_radicand = acc_d[2*SW-1:0];
   end

   // State and datapath registers; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         step_q      <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_rms_q   <= '0;
         out_mean_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_rms_q   <= out_rms_d;
         out_mean_q  <= out_mean_d;
      end
   end

   isqrt_seq #(
      .SW(SW)
   ) u_isqrt (
      .clk      (clk),
      .rst      (rst),
      .start    (sqrt_start),
      .radicand (sqrt_radicand),
      .root     (sqrt_root),
      .done     (sqrt_done)
   );

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = out_valid_q;
   assign bus.out_rms   = out_rms_q;
   assign bus.out_mean  = out_mean_q;

endmodule
